cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter_pkg.sv | 16 +
 rtl/cmp_arbiter_if.sv | 39 +++
 rtl/comparator_lt.sv | 21 ++
 rtl/cmp_arbiter.sv | 101 ++++++++++
 tb/tb_cmp_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_arbiter_pkg.sv
// Shared types and constants for the two-requester compare arbiter.
package cmp_arbiter_pkg;

    localparam int unsigned DEFAULT_N = 32;

    // Mode encoding carried on reqX_sel_signed_i
    localparam logic SIGNED   = 1'b0;
    localparam logic UNSIGNED = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between two requesters, one consumer and the arbiter.
interface cmp_arbiter_if #(
    parameter int unsigned N = cmp_arbiter_pkg::DEFAULT_N
) ();

    logic         req0_valid_i;
    logic         req0_ready_o;
    logic [N-1:0] req0_a_i;
    logic [N-1:0] req0_b_i;
    logic         req0_sel_signed_i;

    logic         req1_valid_i;
    logic         req1_ready_o;
    logic [N-1:0] req1_a_i;
    logic [N-1:0] req1_b_i;
    logic         req1_sel_signed_i;

    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic         rsp_id_o;
    logic         rsp_lt_o;

    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i, req0_sel_signed_i,
        input  req1_valid_i, req1_a_i, req1_b_i, req1_sel_signed_i,
        input  rsp_ready_i,
        output req0_ready_o, req1_ready_o,
        output rsp_valid_o, rsp_id_o, rsp_lt_o
    );

    modport master (
        output req0_valid_i, req0_a_i, req0_b_i, req0_sel_signed_i,
        output req1_valid_i, req1_a_i, req1_b_i, req1_sel_signed_i,
        output rsp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp_valid_o, rsp_id_o, rsp_lt_o
    );

endinterface

// File: rtl/comparator_lt.sv
// Combinational A < B comparator with selectable signed/unsigned interpretation.
module comparator_lt
    import cmp_arbiter_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         selUnsigned,
    output logic         lt_c
);

    // Differing sign bits in signed mode: the negative operand is the smaller one
    always_comb begin
        lt_c = (a < b);
        if ((selUnsigned == SIGNED) && (a[N-1] != b[N-1])) begin
            lt_c = a[N-1];
        end
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparator between two requesters; IDLE -> CMP -> RESP.
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    cmp_arbiter_if.slave bus
);

    state_e       state;
    state_e       stateNext;
    logic         ptr;
    logic         grantId;
    logic         grant0;
    logic         grant1;
    logic         accept;
    logic [N-1:0] opA;
    logic [N-1:0] opB;
    logic         modeQ;
    logic         idQ;
    logic         rspValid;
    logic         rspId;
    logic         rspLt;
    logic         cmpLt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= stateNext;
    end

    // Grant is only offered in IDLE and out of reset; pointer breaks ties
    always_comb begin
        stateNext = state;
        grantId   = 1'b0;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                if (rst_ni) begin
                    if (bus.req0_valid_i && bus.req1_valid_i) grantId = ptr;
                    else                                      grantId = bus.req1_valid_i;
                    grant0 = bus.req0_valid_i && (grantId == 1'b0);
                    grant1 = bus.req1_valid_i && (grantId == 1'b1);
                end
                if (grant0 || grant1) stateNext = CMP;
            end
            CMP:     stateNext = RESP;
            RESP:    if (bus.rsp_ready_i) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign accept = grant0 | grant1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr   <= 1'b0;
            opA   <= '0;
            opB   <= '0;
            modeQ <= SIGNED;
            idQ   <= 1'b0;
        end else if (accept) begin
            ptr   <= ~grantId;
            opA   <= grantId ? bus.req1_a_i : bus.req0_a_i;
            opB   <= grantId ? bus.req1_b_i : bus.req0_b_i;
            modeQ <= grantId ? bus.req1_sel_signed_i : bus.req0_sel_signed_i;
            idQ   <= grantId;
        end
    end

    comparator_lt #(.N(N)) u_cmp (
        .a           (opA),
        .b           (opB),
        .selUnsigned (modeQ),
        .lt_c        (cmpLt)
    );

    // Response is captured at the end of CMP and held until the consumer takes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rspValid <= 1'b0;
            rspId    <= 1'b0;
            rspLt    <= 1'b0;
        end else if (state == CMP) begin
            rspValid <= 1'b1;
            rspId    <= idQ;
            rspLt    <= cmpLt;
        end else if ((state == RESP) && bus.rsp_ready_i) begin
            rspValid <= 1'b0;
        end
    end

    assign bus.req0_ready_o = grant0;
    assign bus.req1_ready_o = grant1;
    assign bus.rsp_valid_o  = rspValid;
    assign bus.rsp_id_o     = rspId;
    assign bus.rsp_lt_o     = rspLt;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomized self-checking bench for cmp_arbiter against a behavioural arbitration/compare model.
module tb_cmp_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors  = 0;
    int   tbPtr   = 0;

    always #5 clk = ~clk;

    cmp_arbiter_if #(.N(32)) bus ();

    cmp_arbiter #(.N(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    function automatic logic model_lt(input logic [31:0] a, input logic [31:0] b, input logic m);
        if (m == 1'b0) return ($signed(a) < $signed(b));
        return (a < b);
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6];
        corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF; corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF; corners[4] = 32'h0000_0001; corners[5] = 32'h8000_0001;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic scramble(input logic vld);
        bus.req0_valid_i = vld;             bus.req1_valid_i = vld;
        bus.req0_a_i = $urandom;            bus.req0_b_i = $urandom;
        bus.req1_a_i = $urandom;            bus.req1_b_i = $urandom;
        bus.req0_sel_signed_i = 1'($urandom); bus.req1_sel_signed_i = 1'($urandom);
    endtask

    // One full transaction from an IDLE negedge back to an IDLE negedge
    task automatic transact(input string tag, input logic v0, input logic v1,
                            input logic [31:0] a0, input logic [31:0] b0, input logic m0,
                            input logic [31:0] a1, input logic [31:0] b1, input logic m1,
                            input int stall);
        int g;
        logic expLt;
        logic [1:0] expRdy;
        bus.req0_valid_i = v0; bus.req0_a_i = a0; bus.req0_b_i = b0; bus.req0_sel_signed_i = m0;
        bus.req1_valid_i = v1; bus.req1_a_i = a1; bus.req1_b_i = b1; bus.req1_sel_signed_i = m1;
        bus.rsp_ready_i  = 1'b0;
        g      = (v0 && v1) ? tbPtr : (v0 ? 0 : 1);
        expRdy = (g == 0) ? 2'b01 : 2'b10;
        expLt  = (g == 0) ? model_lt(a0, b0, m0) : model_lt(a1, b1, m1);
        #1;
        vectors++;
        if ({bus.req1_ready_o, bus.req0_ready_o} !== expRdy) begin
            errors++;
            $display("FAIL %s grant: ready={r1,r0}=%b expected %b", tag, {bus.req1_ready_o, bus.req0_ready_o}, expRdy);
        end
        tbPtr = 1 - g;
        @(negedge clk);
        scramble(1'b1);
        #1;
        vectors++;
        if ({bus.rsp_valid_o, bus.req1_ready_o, bus.req0_ready_o} !== 3'b000) begin
            errors++;
            $display("FAIL %s cmp_phase: {rsp_valid,r1,r0}=%b expected 000", tag,
                     {bus.rsp_valid_o, bus.req1_ready_o, bus.req0_ready_o});
        end
        @(negedge clk);
        vectors++;
        if ({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_lt_o} !== {1'b1, 1'(g), expLt}) begin
            errors++;
            $display("FAIL %s response: {valid,id,lt}=%b expected %b", tag,
                     {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_lt_o}, {1'b1, 1'(g), expLt});
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            scramble(1'b1);
            #1;
            vectors++;
            if ({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_lt_o, bus.req1_ready_o, bus.req0_ready_o}
                    !== {1'b1, 1'(g), expLt, 2'b00}) begin
                errors++;
                $display("FAIL %s stall%0d: {valid,id,lt,r1,r0}=%b expected %b", tag, s,
                         {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_lt_o, bus.req1_ready_o, bus.req0_ready_o},
                         {1'b1, 1'(g), expLt, 2'b00});
            end
        end
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        bus.rsp_ready_i  = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        #1;
        vectors++;
        if ({bus.rsp_valid_o, bus.req1_ready_o, bus.req0_ready_o} !== 3'b000) begin
            errors++;
            $display("FAIL %s release: {rsp_valid,r1,r0}=%b expected 000", tag,
                     {bus.rsp_valid_o, bus.req1_ready_o, bus.req0_ready_o});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        scramble(1'b1);
        bus.rsp_ready_i = 1'b1;
        #3;
        vectors++;
        if ({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_lt_o, bus.req1_ready_o, bus.req0_ready_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: {valid,id,lt,r1,r0}=%b expected 00000",
                     {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_lt_o, bus.req1_ready_o, bus.req0_ready_o});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready_i = 1'b0;
        tbPtr = 0;
    endtask

    task automatic test_signed_unsigned();
        transact("r0_signed",   1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        transact("r0_unsigned", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0, 32'h0, 1'b0, 0);
        transact("r1_only",     1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0000_0003, 32'h0000_0009, 1'b1, 0);
    endtask

    task automatic test_boundaries();
        transact("eq_min_signed",   1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        transact("eq_min_unsigned", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0, 32'h0, 1'b0, 0);
        transact("max_min_signed",  1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 0);
        transact("max_min_unsigned",1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0);
    endtask

    task automatic test_stall();
        transact("stall5", 1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFF0, 1'b0,
                 32'h1234_5678, 32'h1234_5679, 1'b1, 5);
    endtask

    // Both requesters always valid and consumer always ready: one grant every third cycle
    task automatic test_back_to_back();
        logic expLt [$];
        int   expId [$];
        int   g;
        logic [1:0] expRdy;
        scramble(1'b1);
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            expRdy = 2'b00;
            if (i % 3 == 0) begin
                g = tbPtr;
                expRdy = (g == 0) ? 2'b01 : 2'b10;
                expId.push_back(g);
                expLt.push_back((g == 0) ? model_lt(bus.req0_a_i, bus.req0_b_i, bus.req0_sel_signed_i)
                                         : model_lt(bus.req1_a_i, bus.req1_b_i, bus.req1_sel_signed_i));
                tbPtr = 1 - g;
            end
            vectors++;
            if ({bus.req1_ready_o, bus.req0_ready_o} !== expRdy) begin
                errors++;
                $display("FAIL b2b_ready cycle%0d: {r1,r0}=%b expected %b", i, {bus.req1_ready_o, bus.req0_ready_o}, expRdy);
            end
            vectors++;
            if (i % 3 == 2) begin
                if ({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_lt_o} !== {1'b1, 1'(expId[0]), expLt[0]}) begin
                    errors++;
                    $display("FAIL b2b_rsp cycle%0d: {valid,id,lt}=%b expected %b", i,
                             {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_lt_o}, {1'b1, 1'(expId[0]), expLt[0]});
                end
                void'(expId.pop_front());
                void'(expLt.pop_front());
            end else if (bus.rsp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle cycle%0d: rsp_valid=%b expected 0", i, bus.rsp_valid_o);
            end
            @(negedge clk);
            scramble(1'b1);
        end
        scramble(1'b0);
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset_in_cmp();
        scramble(1'b0);
        bus.req0_valid_i = 1'b1;
        @(negedge clk);
        scramble(1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_lt_o, bus.req1_ready_o, bus.req0_ready_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_in_cmp: {valid,id,lt,r1,r0}=%b expected 00000",
                     {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_lt_o, bus.req1_ready_o, bus.req0_ready_o});
        end
        @(negedge clk);
        scramble(1'b0);
        rst_n = 1'b1;
        tbPtr = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: rsp_valid=%b expected 0", bus.rsp_valid_o);
        end
        transact("post_reset_ptr0", 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0006, 1'b1,
                 32'h0000_0006, 32'h0000_0005, 1'b1, 0);
    endtask

    task automatic test_random();
        logic v0;
        logic v1;
        for (int k = 0; k < 40; k++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v1 = 1'b1;
            transact($sformatf("rand%0d", k), v0, v1,
                     pick_operand(), pick_operand(), 1'($urandom),
                     pick_operand(), pick_operand(), 1'($urandom),
                     int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_signed_unsigned();
        test_boundaries();
        test_stall();
        test_back_to_back();
        test_reset_in_cmp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
